// File: rtl/simple_phase_sequencer.sv
// simple_phase_sequencer: run/stop/halt FSM, 5-phase cycle, enables.
// Ports:
//   clk, rst (sync, active-high), exec, step
//   instruction[15:0], S, Z, C, V
//   phase, running, halted, ir_e, ar_e, br_e, dr_e, mdr_e
//   aluc_e, flag_e, mem_e, mem_w, pc_e, pc_br, genr_w, b_imm
//   wb_sel, dst_ra, alu_op, retired, illegal
module simple_phase_sequencer #(
  parameter int CNT_W      = 16,
  parameter bit RUN_ON_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec,
  input  logic             step,
  input  logic [15:0]      instruction,
  input  logic             S,
  input  logic             Z,
  input  logic             C,
  input  logic             V,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic             ir_e,
  output logic             ar_e,
  output logic             br_e,
  output logic             dr_e,
  output logic             mdr_e,
  output logic             aluc_e,
  output logic             flag_e,
  output logic             mem_e,
  output logic             mem_w,
  output logic             pc_e,
  output logic             pc_br,
  output logic             genr_w,
  output logic             b_imm,
  output logic [1:0]       wb_sel,
  output logic             dst_ra,
  output logic [3:0]       alu_op,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       phase_nx;
  logic             stop_req, stop_nx;
  logic             exec_q;
  logic [CNT_W-1:0] ret_nx;
  logic             illegal_q, ill_nx;
  logic             trap, trap_nx;
  logic             rise;

  logic [1:0] op;
  logic [2:0] sub;
  logic [2:0] cnd;
  logic [3:0] fn;
  logic is_alu, is_ld, is_st, is_li, is_b, is_bc;
  logic is_in, is_out, is_hlt, is_sh;
  logic bad, taken, act;
  logic [4:0] p;
  logic unused;

  assign op  = instruction[15:14];
  assign sub = instruction[13:11];
  assign cnd = instruction[10:8];
  assign fn  = instruction[7:4];

  assign is_alu = (op == 2'b11);
  assign is_ld  = (op == 2'b00);
  assign is_st  = (op == 2'b01);
  assign is_li  = (op == 2'b10) & (sub == 3'd0);
  assign is_b   = (op == 2'b10) & (sub == 3'd4);
  assign is_bc  = (op == 2'b10) & (sub == 3'd7) & ~cnd[2];
  assign is_in  = is_alu & (fn == 4'hC);
  assign is_out = is_alu & (fn == 4'hD);
  assign is_hlt = is_alu & (fn == 4'hF);
  assign is_sh  = is_alu & (fn[3:2] == 2'b10);

  assign bad = (is_alu & ((fn == 4'h7) | (fn == 4'hE)))
             | ((op == 2'b10) & ~(is_li | is_b | is_bc));

  always_comb begin
    taken = 1'b0;
    unique case (cnd[1:0])
      2'd0: taken = Z;
      2'd1: taken = S ^ V;
      2'd2: taken = Z | (S ^ V);
      2'd3: taken = ~Z;
      default: taken = 1'b0;
    endcase
  end

  // Trapped instructions lose every enable from the decode phase on.
  assign act = (state == RUN) & ~rst & ~trap
             & ~((phase == 3'd1) & bad);

  always_comb begin
    for (int i = 0; i < 5; i++)
      p[i] = act & (phase == 3'(i));
  end

  assign rise    = exec & ~exec_q;
  assign running = (state == RUN);
  assign halted  = (state == HALT);
  assign illegal = illegal_q
                 | ((state == RUN) & ~rst & (phase == 3'd1) & bad);
  assign unused  = C ^ (^instruction[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN_ON_RST ? RUN : IDLE;
      phase     <= 3'd0;
      stop_req  <= 1'b0;
      exec_q    <= 1'b0;
      retired   <= '0;
      illegal_q <= 1'b0;
      trap      <= 1'b0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      stop_req  <= stop_nx;
      exec_q    <= exec;
      retired   <= ret_nx;
      illegal_q <= ill_nx;
      trap      <= trap_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    stop_nx  = stop_req;
    ret_nx   = retired;
    ill_nx   = illegal_q;
    trap_nx  = trap;
    unique case (state)
      IDLE: if (rise) state_nx = RUN;
      HALT: if (rise) state_nx = IDLE;
      RUN: begin
        stop_nx = stop_req | rise;
        if ((phase == 3'd1) & bad) begin
          ill_nx  = 1'b1;
          trap_nx = 1'b1;
        end
        if (phase == 3'd4) begin
          phase_nx = 3'd0;
          trap_nx  = 1'b0;
          if (retired != '1)
            ret_nx = retired + CNT_W'(1);
          if (trap | is_hlt) begin
            state_nx = HALT;
            stop_nx  = 1'b0;
          end else if (step | stop_nx) begin
            state_nx = IDLE;
            stop_nx  = 1'b0;
          end
        end else begin
          phase_nx = phase + 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ir_e   = 1'b0;
    ar_e   = 1'b0;
    br_e   = 1'b0;
    dr_e   = 1'b0;
    mdr_e  = 1'b0;
    aluc_e = 1'b0;
    flag_e = 1'b0;
    mem_e  = 1'b0;
    mem_w  = 1'b0;
    pc_e   = 1'b0;
    pc_br  = 1'b0;
    genr_w = 1'b0;
    b_imm  = 1'b0;
    wb_sel = 2'd0;
    dst_ra = 1'b0;
    alu_op = 4'd0;
    unique case (1'b1)
      p[0]: begin
        mem_e = 1'b1;
        ir_e  = 1'b1;
      end
      p[1]: begin
        ar_e = is_alu | is_ld | is_st;
        br_e = (is_alu & ~is_in & ~is_hlt) | is_ld | is_st;
      end
      p[2]: begin
        aluc_e = (is_alu & ~is_in & ~is_out & ~is_hlt)
               | is_ld | is_st | is_b | is_bc;
        dr_e   = aluc_e;
        b_imm  = is_sh | is_ld | is_st | is_b | is_bc;
        flag_e = is_alu & (fn <= 4'hB);
        alu_op = is_alu ? fn : 4'd0;
      end
      p[3]: begin
        mem_e = is_ld | is_st;
        mem_w = is_st;
        mdr_e = is_ld | is_in;
      end
      p[4]: begin
        pc_e   = ~is_hlt;
        pc_br  = is_b | (is_bc & taken);
        genr_w = (is_alu & ((fn <= 4'h4) | (fn == 4'h6)
                 | ((fn >= 4'h8) & (fn <= 4'hC))))
               | is_ld | is_li;
        wb_sel = (is_ld | is_in) ? 2'd1 : (is_li ? 2'd2 : 2'd0);
        dst_ra = is_ld;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simple_phase_sequencer.sv
// tb_simple_phase_sequencer: scoreboard bench with reference model.
// Directed scenarios followed by randomized stimulus.
module tb_simple_phase_sequencer;

  localparam int CW   = 4;
  localparam int RMAX = (1 << CW) - 1;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_LI  = 3;
  localparam int K_B   = 4;
  localparam int K_BC  = 5;
  localparam int K_BAD = 6;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst, exec, step, S, Z, C, V;
  logic [15:0] instruction;
  logic [2:0] phase;
  logic running, halted;
  logic ir_e, ar_e, br_e, dr_e, mdr_e, aluc_e, flag_e;
  logic mem_e, mem_w, pc_e, pc_br, genr_w, b_imm, dst_ra;
  logic [1:0] wb_sel;
  logic [3:0] alu_op;
  logic [CW-1:0] retired;
  logic illegal;

  simple_phase_sequencer #(.CNT_W(CW), .RUN_ON_RST(1'b0)) dut (
    .clk(clk), .rst(rst), .exec(exec), .step(step),
    .instruction(instruction),
    .S(S), .Z(Z), .C(C), .V(V),
    .phase(phase), .running(running), .halted(halted),
    .ir_e(ir_e), .ar_e(ar_e), .br_e(br_e), .dr_e(dr_e),
    .mdr_e(mdr_e), .aluc_e(aluc_e), .flag_e(flag_e),
    .mem_e(mem_e), .mem_w(mem_w), .pc_e(pc_e), .pc_br(pc_br),
    .genr_w(genr_w), .b_imm(b_imm), .wb_sel(wb_sel),
    .dst_ra(dst_ra), .alu_op(alu_op), .retired(retired),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          known;
    logic [2:0]    phase;
    logic          running;
    logic          halted;
    logic [19:0]   en;
    logic [CW-1:0] retired;
    logic          illegal;
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;

  int m_state = M_IDLE;
  int m_phase = 0;
  int m_ret = 0;
  bit m_stop = 0, m_ill = 0, m_trap = 0, m_prev = 0, m_known = 0;

  function automatic int kind_of(logic [15:0] i);
    case (i[15:14])
      2'b00: return K_LD;
      2'b01: return K_ST;
      2'b11: return (i[7:4] == 4'd7 || i[7:4] == 4'd14) ? K_BAD : K_ALU;
      default: begin
        if (i[13:11] == 3'd0) return K_LI;
        if (i[13:11] == 3'd4) return K_B;
        if (i[13:11] == 3'd7 && i[10:8] <= 3'd3) return K_BC;
        return K_BAD;
      end
    endcase
  endfunction

  // Enable vector: ir ar br dr mdr aluc flag mem_e mem_w pc_e pc_br
  // genr_w b_imm wb_sel[1:0] dst_ra alu_op[3:0]
  function automatic exp_t predict(bit r, logic [15:0] ins, logic [3:0] f);
    exp_t x;
    int k;
    int fn;
    bit act, sf, zf, vf, cond;
    bit ir, ar, br, dr, mdr, aluc, flg, me, mw, pe, pb, gw, bi, da;
    logic [1:0] wb;
    logic [3:0] ao;
    k  = kind_of(ins);
    fn = int'(ins[7:4]);
    sf = f[3]; zf = f[2]; vf = f[0];
    case (ins[9:8])
      2'd0: cond = zf;
      2'd1: cond = (sf != vf);
      2'd2: cond = zf || (sf != vf);
      default: cond = !zf;
    endcase
    {ir, ar, br, dr, mdr, aluc, flg, me, mw, pe, pb, gw, bi, da} = '0;
    wb = 2'd0;
    ao = 4'd0;
    act = !r && m_state == M_RUN && !m_trap
          && !(m_phase == 1 && k == K_BAD);
    if (act) begin
      case (m_phase)
        0: begin me = 1; ir = 1; end
        1: begin
          ar = (k == K_ALU || k == K_LD || k == K_ST);
          br = (k == K_ALU && fn != 12 && fn != 15)
               || k == K_LD || k == K_ST;
        end
        2: begin
          aluc = (k == K_ALU && !(fn inside {12, 13, 15}))
                 || k inside {K_LD, K_ST, K_B, K_BC};
          dr   = aluc;
          bi   = (k == K_ALU && fn >= 8 && fn <= 11)
                 || k inside {K_LD, K_ST, K_B, K_BC};
          flg  = (k == K_ALU && fn <= 11);
          ao   = (k == K_ALU) ? ins[7:4] : 4'd0;
        end
        3: begin
          me  = (k == K_LD || k == K_ST);
          mw  = (k == K_ST);
          mdr = (k == K_LD) || (k == K_ALU && fn == 12);
        end
        4: begin
          pe = !(k == K_ALU && fn == 15);
          pb = (k == K_B) || (k == K_BC && cond);
          gw = (k == K_ALU && fn inside {0, 1, 2, 3, 4, 6, 8, 9, 10, 11, 12})
               || k == K_LD || k == K_LI;
          if (k == K_LD || (k == K_ALU && fn == 12)) wb = 2'd1;
          else if (k == K_LI) wb = 2'd2;
          da = (k == K_LD);
        end
        default: ;
      endcase
    end
    x.known   = m_known;
    x.phase   = 3'(m_phase);
    x.running = (m_state == M_RUN);
    x.halted  = (m_state == M_HALT);
    x.en      = {ir, ar, br, dr, mdr, aluc, flg, me, mw, pe, pb, gw, bi,
                 wb, da, ao};
    x.retired = CW'(m_ret);
    x.illegal = m_ill || (!r && m_state == M_RUN && m_phase == 1
                          && k == K_BAD);
    return x;
  endfunction

  task automatic model_step(bit r, bit e, bit s, logic [15:0] ins);
    int k;
    bit rise;
    k = kind_of(ins);
    rise = e && !m_prev;
    if (r) begin
      m_state = M_IDLE; m_phase = 0; m_stop = 0; m_ret = 0;
      m_ill = 0; m_trap = 0; m_prev = 0; m_known = 1;
    end else begin
      m_prev = e;
      if (m_state == M_IDLE) begin
        if (rise) m_state = M_RUN;
      end else if (m_state == M_HALT) begin
        if (rise) m_state = M_IDLE;
      end else begin
        if (rise) m_stop = 1;
        if (m_phase == 1 && k == K_BAD) begin
          m_ill = 1;
          m_trap = 1;
        end
        if (m_phase == 4) begin
          if (m_ret < RMAX) m_ret++;
          if (m_trap || (k == K_ALU && ins[7:4] == 4'hF)) begin
            m_state = M_HALT;
            m_stop = 0;
          end else if (s || m_stop) begin
            m_state = M_IDLE;
            m_stop = 0;
          end
          m_phase = 0;
          m_trap = 0;
        end else begin
          m_phase++;
        end
      end
    end
  endtask

  task automatic cyc(bit r, bit e, bit s, logic [15:0] ins,
                     logic [3:0] f);
    rst = r; exec = e; step = s; instruction = ins;
    {S, Z, C, V} = f;
    sb.push_back(predict(r, ins, f));
    @(posedge clk);
    #1;
    model_step(r, e, s, ins);
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, ncyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      ncyc++;
      check("enables",
            32'({ir_e, ar_e, br_e, dr_e, mdr_e, aluc_e, flag_e, mem_e,
                 mem_w, pc_e, pc_br, genr_w, b_imm, wb_sel, dst_ra,
                 alu_op}),
            32'(x.en));
      if (x.known) begin
        check("state", 32'({phase, running, halted}),
              32'({x.phase, x.running, x.halted}));
        check("retired", 32'(retired), 32'(x.retired));
        check("illegal", 32'(illegal), 32'(x.illegal));
      end
    end
  end

  function automatic logic [15:0] rand_ins();
    logic [15:0] i;
    i = 16'($urandom);
    if ($urandom_range(0, 99) < 70) begin
      if (i[15:14] == 2'b10) begin
        case ($urandom_range(0, 2))
          0: i[13:11] = 3'd0;
          1: i[13:11] = 3'd4;
          default: i[13:11] = 3'd7;
        endcase
        i[10] = 1'b0;
      end
      if (i[15:14] == 2'b11 && i[7:4] inside {4'd7, 4'd14, 4'd15})
        i[7:4] = 4'd0;
    end
    return i;
  endfunction

  localparam logic [15:0] ADD = 16'hC000;
  localparam logic [15:0] BLT = 16'hB9FE;
  localparam logic [15:0] HLT = 16'hC0F0;
  localparam logic [15:0] STI = 16'h4A05;
  localparam logic [15:0] ILL = 16'hC070;

  initial begin
    logic [15:0] cur;
    rst = 1; exec = 0; step = 0; instruction = ADD;
    {S, Z, C, V} = 4'b0000;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, ADD, 4'b0000);
    cyc(1, 0, 0, ADD, 4'b0000);
    cyc(0, 0, 0, ADD, 4'b0000);
    // ADD run, then two BLTs with taken / not-taken flags
    cyc(0, 1, 0, ADD, 4'b0000);
    repeat (5) cyc(0, 0, 0, ADD, 4'b0000);
    repeat (5) cyc(0, 0, 0, BLT, 4'b1000);
    repeat (5) cyc(0, 0, 0, BLT, 4'b1001);
    // HLT, then exec to IDLE and exec to RUN
    repeat (5) cyc(0, 0, 0, HLT, 4'b0000);
    repeat (2) cyc(0, 0, 0, ADD, 4'b0000);
    cyc(0, 1, 0, ADD, 4'b0000);
    cyc(0, 0, 0, ADD, 4'b0000);
    cyc(0, 1, 0, ADD, 4'b0000);
    repeat (3) cyc(0, 0, 0, ADD, 4'b0000);
    cyc(1, 0, 0, ADD, 4'b0000);
    // single-step ST
    cyc(0, 1, 1, STI, 4'b0000);
    repeat (7) cyc(0, 0, 1, STI, 4'b0000);
    // stop request in P2
    cyc(0, 1, 0, ADD, 4'b0000);
    cyc(0, 0, 0, ADD, 4'b0000);
    cyc(0, 0, 0, ADD, 4'b0000);
    cyc(0, 1, 0, ADD, 4'b0000);
    repeat (4) cyc(0, 0, 0, ADD, 4'b0000);
    // reset during P3
    cyc(0, 1, 0, ADD, 4'b0000);
    repeat (3) cyc(0, 0, 0, ADD, 4'b0000);
    cyc(1, 0, 0, ADD, 4'b0000);
    repeat (2) cyc(0, 0, 0, ADD, 4'b0000);
    // illegal ALU code 7, then a clean run with illegal still set
    cyc(0, 1, 0, ILL, 4'b0000);
    repeat (7) cyc(0, 0, 0, ILL, 4'b0000);
    cyc(0, 1, 0, ADD, 4'b0000);
    cyc(0, 0, 0, ADD, 4'b0000);
    cyc(0, 1, 0, ADD, 4'b0000);
    repeat (6) cyc(0, 0, 1, ADD, 4'b0000);
    // randomized traffic
    cur = ADD;
    for (int i = 0; i < 1500; i++) begin
      if (m_state != M_RUN || m_phase == 0) cur = rand_ins();
      cyc(($urandom_range(0, 999) < 4),
          ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 10),
          cur, 4'($urandom));
    end
    cyc(0, 0, 0, ADD, 4'b0000);
    repeat (2) @(negedge clk);
    #1;
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
